// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
// The fetch unit is the master: it drives the request and receives the response.
interface if_fetch_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [PC_WIDTH-1:0]   imem_req_addr;
    logic                  imem_rsp_valid;
    logic [INST_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight, and feeds IF/ID
// with registered pc/inst, freezing under stall and bubbling on redirect or miss.
module if_fetch_unit #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h00000013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

    state_e                state_q;
    logic                  drop_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [INST_WIDTH-1:0] hold_q;
    logic [PC_WIDTH-1:0]   pc_out_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  inst_valid_q;

    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   redir_al;

    assign pc_inc   = pc_q + PC_WIDTH'(4);
    assign redir_al = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    // Request is masked while reset is held so nothing leaks out before release.
    assign imem.imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem.imem_req_addr  = pc_q;

    assign pc         = pc_out_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            drop_q       <= 1'b0;
            pc_q         <= RESET_PC;
            hold_q       <= '0;
            pc_out_q     <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q         <= redir_al;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            unique case (state_q)
                S_REQ: begin
                    // Accepted this cycle: its response belongs to the old path.
                    if (imem.imem_req_ready) begin
                        state_q <= S_WAIT;
                        drop_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        state_q <= S_REQ;
                        drop_q  <= 1'b0;
                    end else begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end else begin
            if (!stall) begin
                inst_q       <= NOP_INST;
                inst_valid_q <= 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (imem.imem_req_ready) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (stall) begin
                            hold_q  <= imem.imem_rsp_data;
                            state_q <= S_HOLD;
                        end else begin
                            pc_out_q     <= pc_q;
                            inst_q       <= imem.imem_rsp_data;
                            inst_valid_q <= 1'b1;
                            pc_q         <= pc_inc;
                            state_q      <= S_REQ;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        pc_out_q     <= pc_q;
                        inst_q       <= hold_q;
                        inst_valid_q <= 1'b1;
                        pc_q         <= pc_inc;
                        state_q      <= S_REQ;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, a reset/wrap sequence, and
// random traffic compared against a transaction-level fetch model.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] RPCB = 32'hFFFFFFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redir = 1'b0, rdy = 1'b0, rspv = 1'b0;
    logic [31:0] rpc = '0, rdata = '0;
    logic [31:0] pc_a, inst_a, pc_b, inst_b;
    logic        vld_a, vld_b;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) ia ();
    if_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) ib ();
    assign ia.imem_req_ready = rdy;
    assign ia.imem_rsp_valid = rspv;
    assign ia.imem_rsp_data  = rdata;
    assign ib.imem_req_ready = rdy;
    assign ib.imem_rsp_valid = rspv;
    assign ib.imem_rsp_data  = rdata;

    if_fetch_unit #(.RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redir), .redirect_pc(rpc),
        .imem(ia), .pc(pc_a), .inst(inst_a), .inst_valid(vld_a));
    if_fetch_unit #(.RESET_PC(RPCB)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redir), .redirect_pc(rpc),
        .imem(ib), .pc(pc_b), .inst(inst_b), .inst_valid(vld_b));

    typedef struct {
        logic rst, stall, redir; logic [31:0] rpc;
        logic rdy, rspv; logic [31:0] rdata;
        logic chk, e_rv; logic [31:0] e_addr, e_pc, e_inst; logic e_vld;
    } vec_t;

    // Fetch model: next fetch pc, one outstanding request (busy), whether its
    // data is stale (discard), and a parked instruction waiting out a stall.
    typedef struct {
        logic [31:0] rst_pc, fpc, opc, oinst, hdata;
        bit busy, discard, held, ovld;
    } mdl_t;

    mdl_t ma, mb;

    function automatic vec_t mk(logic s, logic r, logic [31:0] rp, logic rd, logic rv,
                                logic [31:0] d, logic erv, logic [31:0] ea,
                                logic [31:0] ep, logic [31:0] ei, logic ev);
        vec_t v;
        v.rst = 1'b0; v.stall = s; v.redir = r; v.rpc = rp; v.rdy = rd; v.rspv = rv;
        v.rdata = d; v.chk = 1'b1; v.e_rv = erv; v.e_addr = ea; v.e_pc = ep;
        v.e_inst = ei; v.e_vld = ev;
        return v;
    endfunction

    function automatic mdl_t mreset(logic [31:0] rp);
        mdl_t m;
        m.rst_pc = rp; m.fpc = rp; m.opc = rp; m.oinst = NOP; m.hdata = '0;
        m.busy = 0; m.discard = 0; m.held = 0; m.ovld = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m_in, vec_t v);
        mdl_t m;
        bit dlv;
        logic [31:0] dv;
        m = m_in; dlv = 0; dv = '0;
        if (v.rst) return mreset(m.rst_pc);
        if (v.redir) begin
            m.oinst = NOP; m.ovld = 0; m.fpc = {v.rpc[31:2], 2'b00};
            if (m.busy) begin
                if (v.rspv) m.busy = 0;
                m.discard = !v.rspv;
            end else if (m.held) m.held = 0;
            else if (v.rdy) begin m.busy = 1; m.discard = 1; end
            return m;
        end
        if (m.busy) begin
            if (v.rspv) begin
                m.busy = 0;
                if (m.discard) m.discard = 0;
                else if (v.stall) begin m.held = 1; m.hdata = v.rdata; end
                else begin dlv = 1; dv = v.rdata; end
            end
        end else if (m.held) begin
            if (!v.stall) begin m.held = 0; dlv = 1; dv = m.hdata; end
        end else if (v.rdy) m.busy = 1;
        if (dlv) begin
            m.opc = m.fpc; m.oinst = dv; m.ovld = 1; m.fpc = m.fpc + 32'd4;
        end else if (!v.stall) begin
            m.oinst = NOP; m.ovld = 0;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input bit pre);
        if (pre) begin
            chk("mdlA_req_valid", 32'(ia.imem_req_valid), 32'(!rst && !ma.busy && !ma.held));
            chk("mdlA_req_addr", ia.imem_req_addr, ma.fpc);
            chk("mdlB_req_valid", 32'(ib.imem_req_valid), 32'(!rst && !mb.busy && !mb.held));
            chk("mdlB_req_addr", ib.imem_req_addr, mb.fpc);
        end
        chk("mdlA_pc", pc_a, ma.opc);
        chk("mdlA_inst", inst_a, ma.oinst);
        chk("mdlA_valid", 32'(vld_a), 32'(ma.ovld));
        chk("mdlB_pc", pc_b, mb.opc);
        chk("mdlB_inst", inst_b, mb.oinst);
        chk("mdlB_valid", 32'(vld_b), 32'(mb.ovld));
    endtask

    // Inputs change at the falling edge; request side is sampled before the
    // rising edge, registered outputs 1ns after it.
    task automatic cyc(input vec_t v);
        @(negedge clk);
        rst = v.rst; stall = v.stall; redir = v.redir; rpc = v.rpc;
        rdy = v.rdy; rspv = v.rspv; rdata = v.rdata;
        if (v.rst) begin ma = mreset(ma.rst_pc); mb = mreset(mb.rst_pc); end
        #1;
        cmp_model(1'b1);
        if (v.chk) begin
            chk("tbl_req_valid", 32'(ia.imem_req_valid), 32'(v.e_rv));
            chk("tbl_req_addr", ia.imem_req_addr, v.e_addr);
        end
        @(posedge clk);
        ma = mstep(ma, v);
        mb = mstep(mb, v);
        #1;
        cmp_model(1'b0);
        if (v.chk) begin
            chk("tbl_pc", pc_a, v.e_pc);
            chk("tbl_inst", inst_a, v.e_inst);
            chk("tbl_valid", 32'(vld_a), 32'(v.e_vld));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        vec_t tbl[28];
        vec_t v;
        ma = mreset(32'h0);
        mb = mreset(RPCB);

        //           stall redir rpc  rdy rsp data          rv  addr    pc      inst          vld
        tbl[0]  = mk(0, 0, 0,        1, 0, 0,             1, 0,      0,      NOP,          0);
        tbl[1]  = mk(0, 0, 0,        1, 1, 32'h00500093,  0, 0,      0,      32'h00500093, 1);
        tbl[2]  = mk(0, 0, 0,        1, 0, 0,             1, 4,      0,      NOP,          0);
        tbl[3]  = mk(0, 0, 0,        1, 1, 32'h00A00113,  0, 4,      4,      32'h00A00113, 1);
        tbl[4]  = mk(1, 0, 0,        1, 0, 0,             1, 8,      4,      32'h00A00113, 1);
        tbl[5]  = mk(1, 0, 0,        0, 1, 32'h002081B3,  0, 8,      4,      32'h00A00113, 1);
        tbl[6]  = mk(1, 0, 0,        0, 0, 0,             0, 8,      4,      32'h00A00113, 1);
        tbl[7]  = mk(0, 0, 0,        0, 0, 0,             0, 8,      8,      32'h002081B3, 1);
        tbl[8]  = mk(0, 0, 0,        1, 0, 0,             1, 12,     8,      NOP,          0);
        tbl[9]  = mk(0, 1, 32'h100,  0, 0, 0,             0, 12,     8,      NOP,          0);
        tbl[10] = mk(0, 0, 0,        0, 1, 32'hDEADBEEF,  0, 'h100,  8,      NOP,          0);
        tbl[11] = mk(0, 0, 0,        1, 0, 0,             1, 'h100,  8,      NOP,          0);
        tbl[12] = mk(0, 0, 0,        0, 1, 32'h00100093,  0, 'h100,  'h100,  32'h00100093, 1);
        tbl[13] = mk(1, 0, 0,        1, 0, 0,             1, 'h104,  'h100,  32'h00100093, 1);
        tbl[14] = mk(1, 1, 32'h203,  0, 1, 32'h11111111,  0, 'h104,  'h100,  NOP,          0);
        tbl[15] = mk(0, 0, 0,        1, 0, 0,             1, 'h200,  'h100,  NOP,          0);
        tbl[16] = mk(0, 0, 0,        0, 1, 32'h22222222,  0, 'h200,  'h200,  32'h22222222, 1);
        tbl[17] = mk(0, 1, 32'h300,  1, 0, 0,             1, 'h204,  'h200,  NOP,          0);
        tbl[18] = mk(0, 0, 0,        0, 1, 32'h33333333,  0, 'h300,  'h200,  NOP,          0);
        for (int i = 19; i < 24; i++)
            tbl[i] = mk(0, 0, 0,     0, 0, 0,             1, 'h300,  'h200,  NOP,          0);
        tbl[24] = mk(0, 0, 0,        1, 0, 0,             1, 'h300,  'h200,  NOP,          0);
        tbl[25] = mk(0, 0, 0,        1, 0, 0,             0, 'h300,  'h200,  NOP,          0);
        tbl[26] = mk(0, 0, 0,        0, 1, 32'h44444444,  0, 'h300,  'h300,  32'h44444444, 1);
        tbl[27] = mk(0, 0, 0,        0, 0, 0,             1, 'h304,  'h300,  NOP,          0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(ia.imem_req_valid), 32'h0);
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_inst", inst_a, NOP);
        chk("rst_valid", 32'(vld_a), 32'h0);
        chk("rst_pc_b", pc_b, RPCB);

        for (int i = 0; i < 28; i++) cyc(tbl[i]);

        // Wrapping reset PC, then reset while a fetch is outstanding.
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.chk = 0; v.rst = 1;
        cyc(v);
        v.rst = 0;
        cyc(v);
        chk("wrap_first_addr", ib.imem_req_addr, RPCB);
        chk("wrap_first_rv", 32'(ib.imem_req_valid), 32'h1);
        v.rdy = 1;
        cyc(v);
        v.rdy = 0; v.rspv = 1; v.rdata = 32'h0AB00093;
        cyc(v);
        chk("wrap_pc", pc_b, RPCB);
        chk("wrap_inst", inst_b, 32'h0AB00093);
        chk("wrap_second_addr", ib.imem_req_addr, 32'h0);
        v.rspv = 0; v.rdy = 1; v.stall = 1;
        cyc(v);
        chk("pre_rst_valid_b", 32'(vld_b), 32'h1);
        v.rdy = 0; v.stall = 0; v.rst = 1;
        cyc(v);
        chk("midrst_inst_b", inst_b, NOP);
        chk("midrst_valid_b", 32'(vld_b), 32'h0);
        chk("midrst_pc_b", pc_b, RPCB);
        v.rst = 0; v.rspv = 1; v.rdata = 32'h55555555;
        cyc(v);
        chk("late_rsp_valid_b", 32'(vld_b), 32'h0);
        chk("late_rsp_addr_b", ib.imem_req_addr, RPCB);
        chk("late_rsp_rv_b", 32'(ib.imem_req_valid), 32'h1);

        for (int i = 0; i < 800; i++) begin
            v = mk(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                   0, 0, 0, 0, 0);
            v.chk = 0;
            v.rst = 1'($urandom_range(0, 99) == 0);
            cyc(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
